sys_bridge: RTL and testbench

System bridge and interrupt controller between the CPU's memory stage and the memory-mapped timer devices. It decodes CPU addresses, steers write enables and read data to and from two timer instances, and owns a small register file. That register file latches, masks and prioritises device interrupts into the CPU's `HWInt` vector. It is the single point through which the CPU configures, sequences and acknowledges the timers.

---
 rtl/bridge_pkg.sv | 37 +++
 rtl/ic_line.sv | 58 +++++
 rtl/sys_bridge.sv | 144 ++++++++++++++
 tb/tb_sys_bridge.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bridge_pkg
//  Description : Shared constants and helpers for the system bridge and its
//                interrupt controller: window base addresses, IC register
//                word offsets, STAT bit positions and the IRQ line count.
//  Revision    : 1.0  initial release
// ============================================================================
package bridge_pkg;

  localparam int N_IRQ = 2;

  localparam logic [31:0] DEV0_BASE_DEF = 32'h0000_7f00;
  localparam logic [31:0] DEV1_BASE_DEF = 32'h0000_7f10;
  localparam logic [31:0] IC_BASE_DEF   = 32'h0000_7f20;

  // Upper 24 address bits of the device page; stores that miss every window
  // inside this page flag ERR.
  localparam logic [23:0] ERR_PAGE = 24'h00_007f;

  // IC register word offsets within the IC window
  localparam logic [1:0] IC_PEND = 2'd0;
  localparam logic [1:0] IC_MASK = 2'd1;
  localparam logic [1:0] IC_MODE = 2'd2;
  localparam logic [1:0] IC_STAT = 2'd3;

  // STAT field positions
  localparam int STAT_ERR_BIT = 8;
  localparam int STAT_ANY_BIT = 16;

  // Lowest-numbered active line wins; isolate the lowest set bit.
  function automatic logic [N_IRQ-1:0] prio_onehot(input logic [N_IRQ-1:0] act);
    return act & (~act + N_IRQ'(1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/ic_line.sv
`default_nettype none
// ============================================================================
//  Module      : ic_line
//  Description : One interrupt line of the IC: input delay for edge detect,
//                MODE bit and PEND bit with write-1-to-clear.
//  Ports       : clk, reset      - clock, sync active-high reset
//                irq             - raw device interrupt
//                mode_we/mode_wd - MODE register write strobe / data bit
//                w1c             - clear request for PEND (write of a 1)
//                pend, mode      - current PEND and MODE bits
//  Revision    : 1.0  initial release
// ============================================================================
module ic_line (
  input  logic clk,
  input  logic reset,
  input  logic irq,
  input  logic mode_we,
  input  logic mode_wd,
  input  logic w1c,
  output logic pend,
  output logic mode
);

  logic irq_dly_q, irq_dly_d;
  logic pend_q, pend_d;
  logic mode_q, mode_d;
  logic w_rise;

  always_comb begin
    irq_dly_d = irq;
    mode_d    = mode_we ? mode_wd : mode_q;
    w_rise    = irq & ~irq_dly_q;
    if (mode_q) begin
      // Edge mode: a new rising edge beats a coincident clear.
      pend_d = w_rise | (pend_q & ~w1c);
    end else begin
      // Level mode: PEND tracks the input, so a clear cannot stick.
      pend_d = irq;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_dly_q <= 1'b0;
      pend_q    <= 1'b0;
      mode_q    <= 1'b0;
    end else begin
      irq_dly_q <= irq_dly_d;
      pend_q    <= pend_d;
      mode_q    <= mode_d;
    end
  end

  assign pend = pend_q;
  assign mode = mode_q;

endmodule
`default_nettype wire

// File: rtl/sys_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : sys_bridge
//  Description : CPU-to-timer bridge with a two-line interrupt controller.
//                Decodes the CPU word address into two device windows and the
//                IC window, steers write enables and read data, and drives
//                HWInt from masked pending interrupts.
//  Ports       : clk, reset            - clock, sync active-high reset
//                PrAddr/PrWD/PrWE/PrRD - CPU memory-stage bus
//                HWInt                 - interrupt lines to CP0 ([1:0] used)
//                DEV_Addr/DEV_WD       - address/data forwarded to devices
//                DEV0_WE/DEV1_WE       - per-device write enables
//                DEV0_RD/DEV1_RD       - device read data
//                IRQ0/IRQ1             - raw device interrupts
//  Revision    : 1.0  initial release
// ============================================================================
module sys_bridge
  import bridge_pkg::*;
#(
  parameter logic [31:0] DEV0_BASE = DEV0_BASE_DEF,
  parameter logic [31:0] DEV1_BASE = DEV1_BASE_DEF,
  parameter logic [31:0] IC_BASE   = IC_BASE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PrAddr,
  input  logic [31:0] PrWD,
  input  logic        PrWE,
  output logic [31:0] PrRD,
  output logic [5:0]  HWInt,
  output logic [31:0] DEV_Addr,
  output logic [31:0] DEV_WD,
  output logic        DEV0_WE,
  output logic        DEV1_WE,
  input  logic [31:0] DEV0_RD,
  input  logic [31:0] DEV1_RD,
  input  logic        IRQ0,
  input  logic        IRQ1
);

  localparam logic [29:0] DEV0_W = DEV0_BASE[31:2];
  localparam logic [29:0] DEV1_W = DEV1_BASE[31:2];
  localparam logic [29:0] IC_W   = IC_BASE[31:2];

  logic [29:0]      w_word;
  logic             w_sel0, w_sel1, w_selic, w_unmapped;
  logic [1:0]       w_ic_off;
  logic             w_ic_we;
  logic [N_IRQ-1:0] w_irq, w_w1c, w_pend, w_mode, w_act;
  logic             w_mode_we;
  logic [31:0]      w_stat;

  logic [N_IRQ-1:0] mask_q, mask_d;
  logic             err_q, err_d;

  // ---------------------------------------------------------------- decode
  assign w_word     = PrAddr[31:2];
  assign w_sel0     = (w_word >= DEV0_W) && (w_word <= DEV0_W + 30'd2);
  assign w_sel1     = (w_word >= DEV1_W) && (w_word <= DEV1_W + 30'd2);
  assign w_selic    = (w_word >= IC_W)   && (w_word <= IC_W + 30'd3);
  assign w_unmapped = !(w_sel0 || w_sel1 || w_selic);
  // Only the low two bits of the offset matter inside the 4-word window.
  assign w_ic_off   = w_word[1:0] - IC_W[1:0];
  assign w_ic_we    = PrWE && w_selic;

  assign DEV_Addr = PrAddr;
  assign DEV_WD   = PrWD;
  assign DEV0_WE  = PrWE && w_sel0;
  assign DEV1_WE  = PrWE && w_sel1;

  // ---------------------------------------------------------- IC lines
  assign w_irq     = {IRQ1, IRQ0};
  assign w_mode_we = w_ic_we && (w_ic_off == IC_MODE);
  assign w_w1c     = (w_ic_we && (w_ic_off == IC_PEND)) ? PrWD[N_IRQ-1:0] : '0;

  for (genvar i = 0; i < N_IRQ; i++) begin : g_line
    ic_line u_line (
      .clk     (clk),
      .reset   (reset),
      .irq     (w_irq[i]),
      .mode_we (w_mode_we),
      .mode_wd (PrWD[i]),
      .w1c     (w_w1c[i]),
      .pend    (w_pend[i]),
      .mode    (w_mode[i])
    );
  end

  // ------------------------------------------------------ MASK / ERR regs
  always_comb begin
    mask_d = mask_q;
    if (w_ic_we && (w_ic_off == IC_MASK)) begin
      mask_d = PrWD[N_IRQ-1:0];
    end
    err_d = err_q;
    // A stray store is never also a STAT write, so the order is immaterial.
    if (PrWE && w_unmapped && (PrAddr[31:8] == ERR_PAGE)) begin
      err_d = 1'b1;
    end else if (w_ic_we && (w_ic_off == IC_STAT)) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q <= '0;
      err_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      err_q  <= err_d;
    end
  end

  // ------------------------------------------- active lines, STAT, HWInt
  // PEND and MASK are both flops, so HWInt has no combinational IRQ path.
  assign w_act = w_pend & mask_q;
  assign HWInt = {{(6 - N_IRQ){1'b0}}, w_act};

  always_comb begin
    w_stat                = '0;
    w_stat[N_IRQ-1:0]     = prio_onehot(w_act);
    w_stat[STAT_ERR_BIT]  = err_q;
    w_stat[STAT_ANY_BIT]  = |w_act;
  end

  // ------------------------------------------------------------ read mux
  always_comb begin
    PrRD = '0;
    if (w_sel0) begin
      PrRD = DEV0_RD;
    end else if (w_sel1) begin
      PrRD = DEV1_RD;
    end else if (w_selic) begin
      case (w_ic_off)
        IC_PEND: PrRD = {{(32 - N_IRQ){1'b0}}, w_pend};
        IC_MASK: PrRD = {{(32 - N_IRQ){1'b0}}, mask_q};
        IC_MODE: PrRD = {{(32 - N_IRQ){1'b0}}, w_mode};
        default: PrRD = w_stat;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sys_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sys_bridge
//  Description : Self-checking bench for sys_bridge: a table of decode/read
//                mux vectors followed by directed interrupt-controller
//                sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sys_bridge;

  localparam logic [31:0] D0 = 32'hA5A5_0001;
  localparam logic [31:0] D1 = 32'h5A5A_0002;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PrAddr, PrWD, PrRD;
  logic        PrWE;
  logic [5:0]  HWInt;
  logic [31:0] DEV_Addr, DEV_WD;
  logic        DEV0_WE, DEV1_WE;
  logic [31:0] DEV0_RD, DEV1_RD;
  logic        IRQ0, IRQ1;

  int total = 0;
  int bad   = 0;

  sys_bridge dut (
    .clk      (clk),
    .reset    (reset),
    .PrAddr   (PrAddr),
    .PrWD     (PrWD),
    .PrWE     (PrWE),
    .PrRD     (PrRD),
    .HWInt    (HWInt),
    .DEV_Addr (DEV_Addr),
    .DEV_WD   (DEV_WD),
    .DEV0_WE  (DEV0_WE),
    .DEV1_WE  (DEV1_WE),
    .DEV0_RD  (DEV0_RD),
    .DEV1_RD  (DEV1_RD),
    .IRQ0     (IRQ0),
    .IRQ1     (IRQ1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] exp_rd;
    logic        exp_we0;
    logic        exp_we1;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    PrAddr = addr;
    PrWD   = data;
    PrWE   = 1'b1;
    cyc();
    PrWE   = 1'b0;
  endtask

  task automatic rdchk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    PrAddr = addr;
    PrWE   = 1'b0;
    #1;
    chk(name, PrRD, exp);
  endtask

  task automatic hwchk(input string name, input logic [5:0] exp);
    chk(name, {26'b0, HWInt}, {26'b0, exp});
  endtask

  initial begin
    vecs[0]  = '{32'h0000_7f00, 1'b1, D0,    1'b1, 1'b0};
    vecs[1]  = '{32'h0000_7f08, 1'b1, D0,    1'b1, 1'b0};
    vecs[2]  = '{32'h0000_7f0c, 1'b1, 32'h0, 1'b0, 1'b0};
    vecs[3]  = '{32'h0000_7f10, 1'b0, D1,    1'b0, 1'b0};
    vecs[4]  = '{32'h0000_7f14, 1'b1, D1,    1'b0, 1'b1};
    vecs[5]  = '{32'h0000_7f18, 1'b1, D1,    1'b0, 1'b1};
    vecs[6]  = '{32'h0000_7f1c, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[7]  = '{32'h0000_7f40, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[8]  = '{32'h0000_7efc, 1'b1, 32'h0, 1'b0, 1'b0};
    vecs[9]  = '{32'h0001_7f00, 1'b1, 32'h0, 1'b0, 1'b0};
    vecs[10] = '{32'h0000_7f03, 1'b1, D0,    1'b1, 1'b0};

    reset   = 1'b1;
    PrAddr  = '0;
    PrWD    = '0;
    PrWE    = 1'b0;
    DEV0_RD = D0;
    DEV1_RD = D1;
    IRQ0    = 1'b0;
    IRQ1    = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;

    // Reset state
    hwchk("rst_hwint", 6'b0);
    rdchk("rst_pend", 32'h7f20, 32'h0);
    rdchk("rst_mask", 32'h7f24, 32'h0);
    rdchk("rst_mode", 32'h7f28, 32'h0);
    rdchk("rst_stat", 32'h7f2c, 32'h0);

    // Decode / read mux table; the store strobe is dropped before any edge
    for (int i = 0; i < 11; i++) begin
      cyc();
      PrAddr = vecs[i].addr;
      PrWD   = 32'h9;
      PrWE   = vecs[i].we;
      #1;
      chk($sformatf("vec%0d_rd", i),  PrRD, vecs[i].exp_rd);
      chk($sformatf("vec%0d_we0", i), {31'b0, DEV0_WE}, {31'b0, vecs[i].exp_we0});
      chk($sformatf("vec%0d_we1", i), {31'b0, DEV1_WE}, {31'b0, vecs[i].exp_we1});
      chk($sformatf("vec%0d_addr", i), DEV_Addr, vecs[i].addr);
      chk($sformatf("vec%0d_wd", i), DEV_WD, 32'h9);
      PrWE = 1'b0;
    end
    #1;
    chk("we0_one_cycle", {31'b0, DEV0_WE}, 32'h0);
    rdchk("no_err_from_table", 32'h7f2c, 32'h0);

    // Edge mode, single line
    wr(32'h7f28, 32'h1);
    wr(32'h7f24, 32'h1);
    IRQ0 = 1'b1;
    cyc();
    IRQ0 = 1'b0;
    hwchk("edge_hw_set", 6'b000001);
    rdchk("edge_pend", 32'h7f20, 32'h1);
    cyc();
    hwchk("edge_hw_hold", 6'b000001);
    wr(32'h7f20, 32'h1);
    hwchk("edge_hw_w1c", 6'b0);

    // Both lines, priority
    wr(32'h7f28, 32'h3);
    rdchk("mode_rw", 32'h7f28, 32'h3);
    wr(32'h7f24, 32'hffff_ffff);
    rdchk("mask_upper0", 32'h7f24, 32'h3);
    IRQ0 = 1'b1;
    IRQ1 = 1'b1;
    cyc();
    IRQ0 = 1'b0;
    IRQ1 = 1'b0;
    hwchk("both_hw", 6'b000011);
    rdchk("both_stat", 32'h7f2c, 32'h0001_0001);
    wr(32'h7f20, 32'h1);
    rdchk("prio_l1_stat", 32'h7f2c, 32'h0001_0002);
    wr(32'h7f20, 32'h2);
    hwchk("both_cleared", 6'b0);

    // Held IRQ: no retrigger after W1C; a coincident new edge wins
    IRQ0 = 1'b1;
    cyc();
    rdchk("hold_pend", 32'h7f20, 32'h1);
    wr(32'h7f20, 32'h1);
    rdchk("hold_no_retrig", 32'h7f20, 32'h0);
    IRQ0 = 1'b0;
    cyc();
    IRQ0 = 1'b1;
    wr(32'h7f20, 32'h1);
    rdchk("set_wins", 32'h7f20, 32'h1);
    IRQ0 = 1'b0;
    wr(32'h7f20, 32'h1);
    rdchk("set_wins_clr", 32'h7f20, 32'h0);

    // Level mode on line 1: 3-cycle pulse, then mask removal mid-pulse
    wr(32'h7f28, 32'h0);
    wr(32'h7f24, 32'h2);
    IRQ1 = 1'b1;
    #1;
    hwchk("lvl_c0", 6'b0);
    cyc();
    hwchk("lvl_c1", 6'b000010);
    cyc();
    hwchk("lvl_c2", 6'b000010);
    cyc();
    hwchk("lvl_c3", 6'b000010);
    IRQ1 = 1'b0;
    cyc();
    hwchk("lvl_c4", 6'b0);
    IRQ1 = 1'b1;
    cyc();
    hwchk("lvl_m_on", 6'b000010);
    wr(32'h7f24, 32'h0);
    hwchk("lvl_m_off", 6'b0);
    rdchk("lvl_m_pend", 32'h7f20, 32'h2);
    IRQ1 = 1'b0;
    cyc();
    rdchk("lvl_pend_fall", 32'h7f20, 32'h0);

    // ERR sticky bit
    wr(32'h7f3c, 32'h0);
    rdchk("err_set", 32'h7f2c, 32'h0000_0100);
    cyc();
    rdchk("err_sticky", 32'h7f2c, 32'h0000_0100);
    wr(32'h7f2c, 32'h0);
    rdchk("err_clr", 32'h7f2c, 32'h0);

    // Reset mid-operation
    wr(32'h7f28, 32'h3);
    wr(32'h7f24, 32'h3);
    wr(32'h7f40, 32'h0);
    IRQ0 = 1'b1;
    IRQ1 = 1'b1;
    cyc();
    IRQ0 = 1'b0;
    IRQ1 = 1'b0;
    rdchk("pre_rst_pend", 32'h7f20, 32'h3);
    rdchk("pre_rst_stat", 32'h7f2c, 32'h0001_0101);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    hwchk("mid_rst_hwint", 6'b0);
    rdchk("mid_rst_pend", 32'h7f20, 32'h0);
    rdchk("mid_rst_mask", 32'h7f24, 32'h0);
    rdchk("mid_rst_mode", 32'h7f28, 32'h0);
    rdchk("mid_rst_stat", 32'h7f2c, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
